// File: rtl/seq_wide_alu_pkg.sv
// Shared types for the sequential wide ALU.
// Op encoding, FSM states and the MUL iteration count.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_SUB  = 2'b00,
    OP_RSVD = 2'b01,
    OP_MUL  = 2'b10,
    OP_ADD  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } alu_state_e;

  function automatic int mul_iters(
    input int width,
    input int step
  );
    return width / step;
  endfunction

endpackage

// File: rtl/seq_wide_alu_if.sv
// Operand/result handshake bundle of the sequential wide ALU.
// master drives operands and out_ready; slave is the ALU.
interface seq_wide_alu_if #(
  parameter int WIDTH = 512
) ();
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  alu_op_e          operation;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] D;
  logic             busy;

  modport master (
    output in_valid,
    output operation,
    output A,
    output B,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  C,
    input  D,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  operation,
    input  A,
    input  B,
    input  out_ready,
    output in_ready,
    output out_valid,
    output C,
    output D,
    output busy
  );

endinterface

// File: rtl/seq_wide_alu_mul_core.sv
// Iterative unsigned shift-add multiplier with final sign fix.
// Retires MUL_STEP multiplier bits per cycle after start.
module seq_mul_core
  import alu_pkg::*;
#(
  parameter int WIDTH    = 512,
  parameter int MUL_STEP = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [WIDTH-1:0]   b_mag,
  input  logic               neg,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int W2 = 2 * WIDTH;
  localparam int N  = mul_iters(WIDTH, MUL_STEP);
  localparam int CW = $clog2(N + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    mcand_q, mcand_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             neg_q, neg_d;
  logic [W2-1:0]    part;
  logic [W2-1:0]    acc_nxt;

  always_comb begin
    part = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (mplier_q[i]) begin
        part = part + (mcand_q << i);
      end
    end
    acc_nxt = acc_q + part;
  end

  always_comb begin
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    if (start) begin
      cnt_d    = CW'(N);
      mcand_d  = {{WIDTH{1'b0}}, a_mag};
      acc_d    = '0;
      mplier_d = b_mag;
      neg_d    = neg;
    end else if (cnt_q != '0) begin
      cnt_d    = cnt_q - CW'(1);
      mcand_d  = mcand_q << MUL_STEP;
      acc_d    = acc_nxt;
      mplier_d = mplier_q >> MUL_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
    end
  end

  // Final step and sign fix land together on the DONE entry edge.
  assign done    = (cnt_q == CW'(1));
  assign product = neg_q ? -acc_nxt : acc_nxt;

endmodule

// File: rtl/seq_wide_alu.sv
// Sequential signed ADD/SUB/MUL with 2*WIDTH exact result.
// One op in flight; result held in DONE until out_ready.
module seq_wide_alu
  import alu_pkg::*;
#(
  parameter int WIDTH    = 512,
  parameter int MUL_STEP = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_wide_alu_if.slave  bus
);

  localparam int W2 = 2 * WIDTH;

  alu_state_e       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [W2-1:0]    res_q, res_d;

  logic             accept;
  logic             op_add, op_sub, op_mul;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sum, diff;
  logic [W2-1:0]    addsub_res;
  logic             mul_done;
  logic [W2-1:0]    mul_prod;

  assign accept = bus.in_valid && in_ready_q;
  assign op_add = (bus.operation == OP_ADD);
  assign op_sub = (bus.operation == OP_SUB);
  assign op_mul = (bus.operation == OP_MUL);

  assign a_neg = bus.A[WIDTH-1];
  assign b_neg = bus.B[WIDTH-1];
  assign a_mag = a_neg ? -bus.A : bus.A;
  assign b_mag = b_neg ? -bus.B : bus.B;

  assign sum  = {a_neg, bus.A} + {b_neg, bus.B};
  assign diff = {a_neg, bus.A} - {b_neg, bus.B};

  always_comb begin
    addsub_res = '0;
    unique case (1'b1)
      op_add:  addsub_res = {{(WIDTH-1){sum[WIDTH]}}, sum};
      op_sub:  addsub_res = {{(WIDTH-1){diff[WIDTH]}}, diff};
      default: addsub_res = '0;
    endcase
  end

  seq_mul_core #(
    .WIDTH    (WIDTH),
    .MUL_STEP (MUL_STEP)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && op_mul),
    .a_mag   (a_mag),
    .b_mag   (b_mag),
    .neg     (a_neg ^ b_neg),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    res_d       = res_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          if (op_mul) begin
            state_d = ST_MUL;
          end else begin
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
            res_d       = addsub_res;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          res_d       = mul_prod;
        end
      end
      ST_DONE: begin
        // Returning to IDLE here forces a one-cycle bubble.
        if (bus.out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      res_q       <= res_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.C         = res_q[WIDTH-1:0];
  assign bus.D         = res_q[W2-1:WIDTH];

endmodule

// File: tb/tb_seq_wide_alu.sv
// Bench for seq_wide_alu: WIDTH=8/MUL_STEP=2 and default 512/4.
// Vector table, random ops vs arithmetic model, abort sequence.
module tb_seq_wide_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8_n;
  logic rst5_n;
  int   checks   = 0;
  int   failures = 0;

  seq_wide_alu_if #(.WIDTH(8))   b8 ();
  seq_wide_alu_if #(.WIDTH(512)) b5 ();

  seq_wide_alu #(.WIDTH(8), .MUL_STEP(2)) u8 (
    .clk   (clk),
    .rst_n (rst8_n),
    .bus   (b8.slave)
  );

  seq_wide_alu #(.WIDTH(512), .MUL_STEP(4)) u5 (
    .clk   (clk),
    .rst_n (rst5_n),
    .bus   (b5.slave)
  );

  typedef struct {
    alu_op_e     op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [1023:0] got,
                     input logic [1023:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge.
  task automatic run8(input alu_op_e op, input logic [7:0] a,
                      input logic [7:0] b, input logic [15:0] exp,
                      input int lat, input int hold, input string nm);
    int k;
    logic [15:0] got;
    b8.operation = op;
    b8.A         = a;
    b8.B         = b;
    b8.in_valid  = 1'b1;
    b8.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    k = 1;
    while (!b8.out_valid && k < 40) begin
      b8.A         = 8'($urandom);
      b8.B         = 8'($urandom);
      b8.operation = alu_op_e'(2'($urandom));
      @(negedge clk);
      k++;
    end
    chk({nm, "_lat"}, 1024'(k), 1024'(lat));
    got = {b8.D, b8.C};
    chk({nm, "_res"}, 1024'(got), 1024'(exp));
    for (int h = 0; h < hold; h++) begin
      b8.A = 8'($urandom);
      b8.B = 8'($urandom);
      @(negedge clk);
      chk({nm, "_hold"}, {b8.out_valid, b8.in_ready, b8.D, b8.C},
          {1'b1, 1'b0, exp});
    end
    b8.in_valid  = 1'b0;
    b8.out_ready = 1'b1;
    @(negedge clk);
    b8.out_ready = 1'b0;
    chk({nm, "_bubble"}, {b8.in_ready, b8.out_valid, b8.busy}, 3'b100);
  endtask

  task automatic run512(input alu_op_e op, input logic [511:0] a,
                        input logic [511:0] b, input logic [1023:0] exp,
                        input int lat, input string nm);
    int k;
    b5.operation = op;
    b5.A         = a;
    b5.B         = b;
    b5.in_valid  = 1'b1;
    b5.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    b5.in_valid = 1'b0;
    k = 1;
    while (!b5.out_valid && k < 300) begin
      b5.A = {16{32'($urandom)}};
      b5.B = {16{32'($urandom)}};
      @(negedge clk);
      k++;
    end
    chk({nm, "_lat"}, 1024'(k), 1024'(lat));
    chk({nm, "_res"}, {b5.D, b5.C}, exp);
    b5.out_ready = 1'b1;
    @(negedge clk);
    b5.out_ready = 1'b0;
    chk({nm, "_bubble"}, 1024'(b5.in_ready), 1024'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]           ra, rb;
    alu_op_e              rop;
    int                   ia, ib, r;
    logic [15:0]          rexp;
    logic [511:0]         a5, b5v, bmax;
    logic signed [1023:0] ea, eb;
    logic [1023:0]        e5;
    bit                   seen;

    vecs[0]  = '{OP_ADD,  8'hF8, 8'h07, 16'hFFFF, 1, 0};
    vecs[1]  = '{OP_ADD,  8'h7F, 8'h01, 16'h0080, 1, 0};
    vecs[2]  = '{OP_MUL,  8'h80, 8'h80, 16'h4000, 5, 0};
    vecs[3]  = '{OP_MUL,  8'h06, 8'hFB, 16'hFFE2, 5, 0};
    vecs[4]  = '{OP_SUB,  8'h80, 8'h01, 16'hFF7F, 1, 0};
    vecs[5]  = '{OP_RSVD, 8'h05, 8'h05, 16'h0000, 1, 0};
    vecs[6]  = '{OP_ADD,  8'h80, 8'h80, 16'hFF00, 1, 2};
    vecs[7]  = '{OP_SUB,  8'h7F, 8'h80, 16'h00FF, 1, 0};
    vecs[8]  = '{OP_MUL,  8'h00, 8'hB3, 16'h0000, 5, 0};
    vecs[9]  = '{OP_MUL,  8'h7F, 8'h80, 16'hC080, 5, 0};
    vecs[10] = '{OP_MUL,  8'h09, 8'hFD, 16'hFFE5, 5, 10};
    vecs[11] = '{OP_SUB,  8'h00, 8'h80, 16'h0080, 1, 3};

    rst8_n       = 1'b0;
    rst5_n       = 1'b0;
    b8.in_valid  = 1'b0;
    b8.out_ready = 1'b0;
    b8.operation = OP_ADD;
    b8.A         = '0;
    b8.B         = '0;
    b5.in_valid  = 1'b0;
    b5.out_ready = 1'b0;
    b5.operation = OP_ADD;
    b5.A         = '0;
    b5.B         = '0;
    repeat (3) @(negedge clk);
    rst8_n = 1'b1;
    rst5_n = 1'b1;
    @(negedge clk);
    chk("rst8", {b8.in_ready, b8.out_valid, b8.busy, b8.D, b8.C},
        {3'b100, 16'h0});
    chk("rst512", {b5.in_ready, b5.out_valid, b5.busy},
        1024'(3'b100));
    chk("rst512_cd", {b5.D, b5.C}, 1024'(0));

    for (int i = 0; i < 12; i++) begin
      run8(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
           vecs[i].lat, vecs[i].hold, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 120; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rop = alu_op_e'(2'($urandom));
      ia  = int'($signed(ra));
      ib  = int'($signed(rb));
      case (rop)
        OP_ADD:  r = ia + ib;
        OP_SUB:  r = ia - ib;
        OP_MUL:  r = ia * ib;
        default: r = 0;
      endcase
      rexp = r[15:0];
      run8(rop, ra, rb, rexp, (rop == OP_MUL) ? 5 : 1,
           int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end

    a5   = {512{1'b1}};
    bmax = {1'b0, {511{1'b1}}};
    e5   = 1024'(0) - {512'b0, bmax};
    run512(OP_MUL, a5, bmax, e5, 129, "w512_mul_m1");

    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 16; j++) begin
        a5[j*32 +: 32]  = $urandom;
        b5v[j*32 +: 32] = $urandom;
      end
      if (i == 2) a5 = {1'b1, 511'b0};
      ea = $signed(a5);
      eb = $signed(b5v);
      run512(OP_MUL, a5, b5v, ea * eb, 129, $sformatf("w512_mul%0d", i));
      run512(OP_ADD, a5, b5v, ea + eb, 1, $sformatf("w512_add%0d", i));
      run512(OP_SUB, a5, b5v, ea - eb, 1, $sformatf("w512_sub%0d", i));
    end
    ea = $signed(bmax);
    run512(OP_ADD, bmax, bmax, ea + ea, 1, "w512_add_ovf");

    b5.operation = OP_MUL;
    b5.A         = bmax;
    b5.B         = bmax;
    b5.in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b5.in_valid = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_busy", {b5.busy, b5.out_valid}, 1024'(2'b10));
    rst5_n = 1'b0;
    #1;
    chk("abort_rst", {b5.in_ready, b5.out_valid, b5.busy},
        1024'(3'b100));
    chk("abort_cd", {b5.D, b5.C}, 1024'(0));
    @(negedge clk);
    rst5_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (b5.out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", 1024'(seen), 1024'(0));
    chk("abort_ready", 1024'(b5.in_ready), 1024'(1));
    ea = $signed(bmax);
    eb = -1;
    run512(OP_ADD, bmax, {512{1'b1}}, ea + eb, 1, "w512_after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
